// File: rtl/hcsr04_defs.sv
// Shared definitions for the HC-SR04 measurement sequencer: FSM states and
// default 50 MHz timing constants.
package hcsr04_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_HOLDOFF
  } state_t;

  localparam int unsigned DEF_TRIG_CYC   = 500;
  localparam int unsigned DEF_CM_CYC     = 2941;
  localparam int unsigned DEF_MAX_CM     = 400;
  localparam int unsigned DEF_WAIT_CYC   = 1_500_000;
  localparam int unsigned DEF_PERIOD_CYC = 3_000_000;
  localparam int unsigned DEF_DIST_LEN   = 9;

  // Bits needed for a counter running 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hcsr04_echo_sync.sv
// Echo input synchronizer with registered rise/fall pulses.
// Define HCSR04_ECHO_FILTER_EN to add a 3-sample glitch filter (latency 5 instead of 3).
module hcsr04_echo_sync (
  input  logic CLK,
  input  logic RST_n,
  input  logic I_ECHO,
  output logic O_ECHO_S,
  output logic O_RISE,
  output logic O_FALL
);

  logic [1:0] sync_q;
  logic       echo_nxt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], I_ECHO};
  end

`ifdef HCSR04_ECHO_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) hist_q <= '0;
    else        hist_q <= {hist_q[0], sync_q[1]};
  end

  // Follow the synchronized input only once three consecutive samples agree.
  always_comb begin
    echo_nxt = O_ECHO_S;
    if (sync_q[1] == hist_q[0] && hist_q[0] == hist_q[1])
      echo_nxt = sync_q[1];
  end
`else
  always_comb begin
    echo_nxt = sync_q[1];
  end
`endif

  // Edge pulses are registered alongside echo_s so both change on the same edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      O_ECHO_S <= 1'b0;
      O_RISE   <= 1'b0;
      O_FALL   <= 1'b0;
    end else begin
      O_ECHO_S <= echo_nxt;
      O_RISE   <= echo_nxt & ~O_ECHO_S;
      O_FALL   <= ~echo_nxt & O_ECHO_S;
    end
  end

endmodule

// File: rtl/hcsr04_meas_ctrl.sv
// HC-SR04 measurement sequencer: trigger, echo timing in cm, timeouts, repetition
// hold-off and the free-running cm strobe. Echo filter selected by HCSR04_ECHO_FILTER_EN.
module hcsr04_meas_ctrl
  import hcsr04_defs::*;
#(
  parameter int unsigned TRIG_CYC   = DEF_TRIG_CYC,
  parameter int unsigned CM_CYC     = DEF_CM_CYC,
  parameter int unsigned MAX_CM     = DEF_MAX_CM,
  parameter int unsigned WAIT_CYC   = DEF_WAIT_CYC,
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int unsigned DIST_LEN   = DEF_DIST_LEN
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic                I_EN,
  input  logic                I_ECHO,
  output logic                O_TRIG,
  output logic                O_ST,
  output logic [DIST_LEN-1:0] O_DIST,
  output logic                O_DIST_VLD,
  output logic                O_TIMEOUT,
  output logic                O_BUSY
);

  localparam int unsigned PH_MAX = (WAIT_CYC > TRIG_CYC) ? WAIT_CYC : TRIG_CYC;
  localparam int unsigned PH_W   = cnt_width(PH_MAX);
  localparam int unsigned PRE_W  = cnt_width(CM_CYC);
  localparam int unsigned PER_W  = cnt_width(PERIOD_CYC);

  localparam logic [PH_W-1:0]     TRIG_LAST = PH_W'(TRIG_CYC - 1);
  localparam logic [PH_W-1:0]     WAIT_LAST = PH_W'(WAIT_CYC - 1);
  localparam logic [PRE_W-1:0]    CM_LAST   = PRE_W'(CM_CYC - 1);
  localparam logic [PER_W-1:0]    PER_LAST  = PER_W'(PERIOD_CYC - 1);
  localparam logic [DIST_LEN-1:0] DIST_MAX  = DIST_LEN'(MAX_CM);

  state_t              state, state_n;
  logic [PH_W-1:0]     ph_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic [PRE_W-1:0]    st_cnt;
  logic [PER_W-1:0]    per_cnt;
  logic [DIST_LEN-1:0] dist_cnt;
  logic                echo_s, echo_rise, echo_fall;
  logic                ph_clr, per_clr, meas_clr, pub, pub_to, cm_wrap;

  hcsr04_echo_sync u_echo_sync (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .I_ECHO   (I_ECHO),
    .O_ECHO_S (echo_s),
    .O_RISE   (echo_rise),
    .O_FALL   (echo_fall)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ph_clr   = 1'b0;
    per_clr  = 1'b0;
    meas_clr = 1'b0;
    pub      = 1'b0;
    pub_to   = 1'b0;
    cm_wrap  = (pre_cnt == CM_LAST);
    case (state)
      ST_IDLE: begin
        if (I_EN) begin
          state_n = ST_TRIG;
          per_clr = 1'b1;
          ph_clr  = 1'b1;
        end
      end
      ST_TRIG: begin
        if (ph_cnt == TRIG_LAST) begin
          state_n = ST_WAIT_ECHO;
          ph_clr  = 1'b1;
        end
      end
      ST_WAIT_ECHO: begin
        if (echo_rise) begin
          state_n  = ST_MEASURE;
          meas_clr = 1'b1;
        end else if (ph_cnt == WAIT_LAST) begin
          state_n = ST_HOLDOFF;
          pub     = 1'b1;
          pub_to  = 1'b1;
        end
      end
      ST_MEASURE: begin
        // Fall has priority: a fall on the overflow cycle publishes MAX_CM.
        if (echo_fall) begin
          state_n = ST_HOLDOFF;
          pub     = 1'b1;
        end else if (cm_wrap && dist_cnt == DIST_MAX) begin
          state_n = ST_HOLDOFF;
          pub     = 1'b1;
          pub_to  = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (per_cnt == PER_LAST && !echo_s) begin
          if (I_EN) begin
            state_n = ST_TRIG;
            per_clr = 1'b1;
            ph_clr  = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                                         ph_cnt <= '0;
    else if (ph_clr)                                    ph_cnt <= '0;
    else if (state == ST_TRIG || state == ST_WAIT_ECHO) ph_cnt <= ph_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)                  per_cnt <= '0;
    else if (per_clr)            per_cnt <= '0;
    else if (per_cnt != PER_LAST) per_cnt <= per_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pre_cnt  <= '0;
      dist_cnt <= '0;
    end else if (meas_clr) begin
      pre_cnt  <= '0;
      dist_cnt <= '0;
    end else if (state == ST_MEASURE) begin
      if (cm_wrap) begin
        pre_cnt <= '0;
        if (dist_cnt != DIST_MAX) dist_cnt <= dist_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      O_DIST     <= '0;
      O_DIST_VLD <= 1'b0;
      O_TIMEOUT  <= 1'b0;
    end else begin
      O_DIST_VLD <= pub;
      O_TIMEOUT  <= pub_to;
      if (pub) O_DIST <= pub_to ? '0 : dist_cnt;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      st_cnt <= '0;
      O_ST   <= 1'b0;
    end else if (st_cnt == CM_LAST) begin
      st_cnt <= '0;
      O_ST   <= 1'b1;
    end else begin
      st_cnt <= st_cnt + 1'b1;
      O_ST   <= 1'b0;
    end
  end

  always_comb begin
    O_TRIG = (state == ST_TRIG);
    O_BUSY = (state == ST_TRIG) || (state == ST_WAIT_ECHO) || (state == ST_MEASURE);
  end

endmodule

// File: tb/tb_hcsr04_meas_ctrl.sv
// Directed self-checking bench for hcsr04_meas_ctrl with shortened timing constants.
// Expected edge latency follows HCSR04_ECHO_FILTER_EN.
module tb_hcsr04_meas_ctrl;

`ifdef HCSR04_ECHO_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       CLK    = 1'b0;
  logic       RST_n  = 1'b0;
  logic       I_EN   = 1'b0;
  logic       I_ECHO = 1'b0;
  logic       O_TRIG, O_ST, O_DIST_VLD, O_TIMEOUT, O_BUSY;
  logic [8:0] O_DIST;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         vld_cnt = 0;
  int         vld_cyc = -1;
  logic [8:0] vld_dist = '0;
  logic       vld_to = 1'b0;
  int         last_rise = 0;
  int         nom_vld0 = 0;

  hcsr04_meas_ctrl #(
    .TRIG_CYC   (5),
    .CM_CYC     (10),
    .MAX_CM     (20),
    .WAIT_CYC   (100),
    .PERIOD_CYC (400),
    .DIST_LEN   (9)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .I_EN       (I_EN),
    .I_ECHO     (I_ECHO),
    .O_TRIG     (O_TRIG),
    .O_ST       (O_ST),
    .O_DIST     (O_DIST),
    .O_DIST_VLD (O_DIST_VLD),
    .O_TIMEOUT  (O_TIMEOUT),
    .O_BUSY     (O_BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (O_DIST_VLD === 1'b1) begin
      vld_cnt  <= vld_cnt + 1;
      vld_cyc  <= cyc;
      vld_dist <= O_DIST;
      vld_to   <= O_TIMEOUT;
    end
  end

  // sel 0: O_TRIG high, 1: O_TRIG low, 2: O_DIST_VLD high. at = -1 if not seen.
  task automatic wait_evt(input int sel, input int limit, output int at);
    bit found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge CLK);
      if ((sel == 0 && O_TRIG === 1'b1) || (sel == 1 && O_TRIG === 1'b0) ||
          (sel == 2 && O_DIST_VLD === 1'b1)) begin
        found = 1'b1;
        at    = cyc;
      end
    end
  endtask

  task automatic test_reset;
    RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_chk++;
    if ({O_TRIG, O_ST, O_DIST_VLD, O_TIMEOUT, O_BUSY} !== 5'b0 || O_DIST !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got trig=%b st=%b vld=%b to=%b busy=%b dist=%0d, expected all 0",
               O_TRIG, O_ST, O_DIST_VLD, O_TIMEOUT, O_BUSY, O_DIST);
    end
    RST_n = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      n_chk++;
      if (O_ST !== (i % 10 == 0)) begin
        n_fail++;
        $display("FAIL idle_st cycle %0d: got %b expected %b", i, O_ST, (i % 10 == 0));
      end
      n_chk++;
      if ({O_TRIG, O_BUSY, O_DIST_VLD, O_TIMEOUT} !== 4'b0 || O_DIST !== 9'd0) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d: got trig=%b busy=%b vld=%b to=%b dist=%0d, expected 0",
                 i, O_TRIG, O_BUSY, O_DIST_VLD, O_TIMEOUT, O_DIST);
      end
    end
  endtask

  task automatic test_nominal;
    int e, t1, f, v;
    @(posedge CLK);
    #1;
    I_EN = 1'b1;
    e    = cyc;
    wait_evt(0, 10, t1);
    n_chk++;
    if (t1 !== e + 1) begin
      n_fail++;
      $display("FAIL nominal_trig_rise: got cycle %0d expected %0d", t1, e + 1);
    end
    n_chk++;
    if (O_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_busy: got %b expected 1", O_BUSY);
    end
    wait_evt(1, 20, f);
    n_chk++;
    if (f - t1 !== 5) begin
      n_fail++;
      $display("FAIL nominal_trig_width: got %0d expected 5", f - t1);
    end
    nom_vld0 = vld_cnt;
    repeat (20) @(posedge CLK);
    #1 I_ECHO = 1'b1;
    repeat (73) @(posedge CLK);
    #1 I_ECHO = 1'b0;
    wait_evt(2, 40, v);
    n_chk++;
    if (v !== f + 94 + LAT) begin
      n_fail++;
      $display("FAIL nominal_vld_time: got cycle %0d expected %0d", v, f + 94 + LAT);
    end
    n_chk++;
    if (O_DIST !== 9'd7 || O_TIMEOUT !== 1'b0 || O_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_result: got dist=%0d to=%b busy=%b expected dist=7 to=0 busy=0",
               O_DIST, O_TIMEOUT, O_BUSY);
    end
    @(negedge CLK);
    n_chk++;
    if (O_DIST_VLD !== 1'b0 || O_DIST !== 9'd7) begin
      n_fail++;
      $display("FAIL nominal_hold: got vld=%b dist=%0d expected vld=0 dist=7", O_DIST_VLD, O_DIST);
    end
    last_rise = t1;
  endtask

  task automatic test_no_echo;
    int t2, f, v;
    wait_evt(0, 400, t2);
    n_chk++;
    if (t2 - last_rise !== 400) begin
      n_fail++;
      $display("FAIL period_nominal: got %0d expected 400", t2 - last_rise);
    end
    n_chk++;
    if (vld_cnt - nom_vld0 !== 1) begin
      n_fail++;
      $display("FAIL nominal_vld_count: got %0d expected 1", vld_cnt - nom_vld0);
    end
    wait_evt(1, 20, f);
    wait_evt(2, 150, v);
    n_chk++;
    if (v - f !== 100) begin
      n_fail++;
      $display("FAIL noecho_timeout_time: got %0d expected 100", v - f);
    end
    n_chk++;
    if (O_DIST !== 9'd0 || O_TIMEOUT !== 1'b1 || O_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL noecho_result: got dist=%0d to=%b busy=%b expected dist=0 to=1 busy=0",
               O_DIST, O_TIMEOUT, O_BUSY);
    end
    last_rise = t2;
  endtask

  // Echo starts 90 cycles after trigger fall and is held 320 cycles so it is
  // still high when the 400-cycle period expires.
  task automatic test_over_range;
    int b, f, n, c0;
    wait_evt(0, 450, b);
    n_chk++;
    if (b - last_rise !== 400) begin
      n_fail++;
      $display("FAIL period_noecho: got %0d expected 400", b - last_rise);
    end
    wait_evt(1, 20, f);
    c0 = vld_cnt;
    repeat (90) @(posedge CLK);
    #1 I_ECHO = 1'b1;
    repeat (320) @(posedge CLK);
    #1 I_ECHO = 1'b0;
    n_chk++;
    if (vld_cnt - c0 !== 1 || vld_cyc !== f + 301 + LAT) begin
      n_fail++;
      $display("FAIL range_vld: got count=%0d cycle=%0d expected count=1 cycle=%0d",
               vld_cnt - c0, vld_cyc, f + 301 + LAT);
    end
    n_chk++;
    if (vld_dist !== 9'd0 || vld_to !== 1'b1) begin
      n_fail++;
      $display("FAIL range_result: got dist=%0d to=%b expected dist=0 to=1", vld_dist, vld_to);
    end
    wait_evt(0, 100, n);
    n_chk++;
    if (n - b !== 416 + LAT) begin
      n_fail++;
      $display("FAIL range_holdoff: got %0d expected %0d", n - b, 416 + LAT);
    end
    last_rise = n;
  endtask

  task automatic test_en_drop;
    int f, v, c0, trigs;
    wait_evt(1, 20, f);
    c0 = vld_cnt;
    repeat (20) @(posedge CLK);
    #1 I_ECHO = 1'b1;
    repeat (30) @(posedge CLK);
    #1 I_EN = 1'b0;
    repeat (25) @(posedge CLK);
    #1 I_ECHO = 1'b0;
    wait_evt(2, 50, v);
    n_chk++;
    if (v !== f + 76 + LAT) begin
      n_fail++;
      $display("FAIL endrop_vld_time: got cycle %0d expected %0d", v, f + 76 + LAT);
    end
    n_chk++;
    if (O_DIST !== 9'd5 || O_TIMEOUT !== 1'b0) begin
      n_fail++;
      $display("FAIL endrop_result: got dist=%0d to=%b expected dist=5 to=0", O_DIST, O_TIMEOUT);
    end
    trigs = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge CLK);
      if (O_TRIG === 1'b1) trigs++;
    end
    n_chk++;
    if (trigs !== 0 || O_BUSY !== 1'b0 || vld_cnt - c0 !== 1) begin
      n_fail++;
      $display("FAIL endrop_idle: got trig_cycles=%0d busy=%b vlds=%0d expected 0 0 1",
               trigs, O_BUSY, vld_cnt - c0);
    end
  endtask

  task automatic test_glitch;
    int d, f, v, exp_v;
    logic exp_to;
`ifdef HCSR04_ECHO_FILTER_EN
    exp_v  = 100;
    exp_to = 1'b1;
`else
    exp_v  = 23 + LAT;
    exp_to = 1'b0;
`endif
    @(posedge CLK);
    #1 I_EN = 1'b1;
    wait_evt(0, 10, d);
    wait_evt(1, 20, f);
    repeat (20) @(posedge CLK);
    #1 I_ECHO = 1'b1;
    repeat (2) @(posedge CLK);
    #1 I_ECHO = 1'b0;
    wait_evt(2, 150, v);
    n_chk++;
    if (v - f !== exp_v) begin
      n_fail++;
      $display("FAIL glitch_vld_time: got %0d expected %0d", v - f, exp_v);
    end
    n_chk++;
    if (O_DIST !== 9'd0 || O_TIMEOUT !== exp_to) begin
      n_fail++;
      $display("FAIL glitch_result: got dist=%0d to=%b expected dist=0 to=%b",
               O_DIST, O_TIMEOUT, exp_to);
    end
    last_rise = d;
  endtask

  // Rise pulse lands on the same cycle the wait counter expires.
  task automatic test_rise_vs_timeout;
    int r, f, v;
    wait_evt(0, 450, r);
    n_chk++;
    if (r - last_rise !== 400) begin
      n_fail++;
      $display("FAIL period_glitch: got %0d expected 400", r - last_rise);
    end
    wait_evt(1, 20, f);
    repeat (99 - LAT) @(posedge CLK);
    #1 I_ECHO = 1'b1;
    repeat (35) @(posedge CLK);
    #1 I_ECHO = 1'b0;
    wait_evt(2, 50, v);
    n_chk++;
    if (v - f !== 135) begin
      n_fail++;
      $display("FAIL rise_wins_time: got %0d expected 135", v - f);
    end
    n_chk++;
    if (O_DIST !== 9'd3 || O_TIMEOUT !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_wins_result: got dist=%0d to=%b expected dist=3 to=0", O_DIST, O_TIMEOUT);
    end
  endtask

  task automatic test_reset_mid;
    int t, trigs;
    wait_evt(0, 450, t);
    @(negedge CLK);
    #1 RST_n = 1'b0;
    #1;
    n_chk++;
    if (O_TRIG !== 1'b0 || O_BUSY !== 1'b0 || O_DIST !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got trig=%b busy=%b dist=%0d expected 0 0 0 (rise seen at %0d)",
               O_TRIG, O_BUSY, O_DIST, t);
    end
    I_EN = 1'b0;
    @(posedge CLK);
    #1 RST_n = 1'b1;
    trigs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (O_TRIG === 1'b1) trigs++;
    end
    n_chk++;
    if (trigs !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got %0d trigger cycles expected 0", trigs);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_no_echo;
    test_over_range;
    test_en_drop;
    test_glitch;
    test_rise_vs_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
